// File: rtl/riscv_pkg.sv
// Shared write-back definitions: write-back type codes, load width codes and capture-stage states.
package riscv_pkg;

    localparam logic [1:0] WB_HICCUP = 2'd0;
    localparam logic [1:0] WB_ALU    = 2'd1;
    localparam logic [1:0] WB_MEM    = 2'd2;
    localparam logic [1:0] WB_PC4    = 2'd3;

    localparam logic [1:0] READ_NONE = 2'd0;
    localparam logic [1:0] READ_BYTE = 2'd1;
    localparam logic [1:0] READ_HALF = 2'd2;
    localparam logic [1:0] READ_WORD = 2'd3;

    // ST_WAIT_MEM marks a captured load; it retires on the first cycle its data is valid.
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_READY    = 2'd1,
        ST_WAIT_MEM = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction: picks the byte/half addressed by the offset and sign- or zero-extends it.
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_readStatus,
    input  logic        i_signed,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_data[{i_offset, 3'b000} +: 8];
        w_half  = i_offset[1] ? i_data[31:16] : i_data[15:0];
        o_value = i_data;
        case (i_readStatus)
            READ_BYTE: o_value = {{24{i_signed & w_byte[7]}}, w_byte};
            READ_HALF: o_value = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_value = i_data;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: capture reg -> commit reg driving the register-file write port and forward channel.
// Optional retire counter enabled by defining WB_RETIRE_COUNTER_EN.
module write_back_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       write_back_type_input,
    input  logic [4:0]       destination_register_number_input,
    input  logic [XLEN-1:0]  alu_result_input,
    input  logic [XLEN-1:0]  pc_input,
    input  logic [1:0]       read_status_input,
    input  logic             load_signed_input,
    input  logic [1:0]       address_low_input,
    input  logic [XLEN-1:0]  mem_read_data,
    input  logic             mem_read_valid,
    output logic             stall_output,
    output logic [4:0]       destination_register_number,
    output logic [XLEN-1:0]  write_back_data,
    output logic [4:0]       write_back_destination_register_number,
    output logic [XLEN-1:0]  write_back_result_forward,
    output logic             write_back_forward_enable,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    wb_state_t       r_state;
    wb_state_t       w_nextState;
    logic [1:0]      r_type;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_pc;
    logic [1:0]      r_readStatus;
    logic            r_signed;
    logic [1:0]      r_addrLow;

    logic [4:0]      r_oRd;
    logic [XLEN-1:0] r_oData;
    logic            r_oFwdEn;

    logic            w_stall;
    logic            w_commit;
    logic [XLEN-1:0] w_loadValue;
    logic [XLEN-1:0] w_commitValue;

    // Stall comes straight from the capture state and this cycle's valid so upstream sees it without delay.
    assign w_stall  = (r_state == ST_WAIT_MEM) && !mem_read_valid;
    assign w_commit = (r_state != ST_EMPTY) && !w_stall;

    load_extract u_loadExtract (
        .i_data       (mem_read_data),
        .i_offset     (r_addrLow),
        .i_readStatus (r_readStatus),
        .i_signed     (r_signed),
        .o_value      (w_loadValue)
    );

    always_comb begin
        w_nextState = r_state;
        if (!w_stall) begin
            case (write_back_type_input)
                WB_HICCUP: w_nextState = ST_EMPTY;
                WB_MEM:    w_nextState = ST_WAIT_MEM;
                default:   w_nextState = ST_READY;
            endcase
        end
    end

    always_comb begin
        w_commitValue = r_alu;
        case (r_type)
            WB_PC4:  w_commitValue = r_pc + PC_STEP;
            WB_MEM:  w_commitValue = w_loadValue;
            default: w_commitValue = r_alu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_type       <= WB_HICCUP;
            r_rd         <= '0;
            r_alu        <= '0;
            r_pc         <= '0;
            r_readStatus <= READ_NONE;
            r_signed     <= 1'b0;
            r_addrLow    <= '0;
        end else if (!w_stall) begin
            r_type       <= write_back_type_input;
            r_rd         <= destination_register_number_input;
            r_alu        <= alu_result_input;
            r_pc         <= pc_input;
            r_readStatus <= read_status_input;
            r_signed     <= load_signed_input;
            r_addrLow    <= address_low_input;
        end
    end

    // Bubbles clear the write address and forward enable but leave the last data on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_oRd    <= '0;
            r_oData  <= '0;
            r_oFwdEn <= 1'b0;
        end else begin
            r_oRd    <= w_commit ? r_rd : 5'd0;
            r_oFwdEn <= w_commit && (r_rd != 5'd0);
            if (w_commit) begin
                r_oData <= w_commitValue;
            end
        end
    end

    assign stall_output                           = w_stall;
    assign destination_register_number            = r_oRd;
    assign write_back_data                        = r_oData;
    assign write_back_destination_register_number = r_oRd;
    assign write_back_result_forward              = r_oData;
    assign write_back_forward_enable              = r_oFwdEn;

`ifdef WB_RETIRE_COUNTER_EN
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_commit) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired_count = r_retired;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: directed scenarios plus randomized ops against a behavioural model.
module tb_write_back_stage;
    import riscv_pkg::*;

    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       write_back_type_input;
    logic [4:0]       destination_register_number_input;
    logic [31:0]      alu_result_input;
    logic [31:0]      pc_input;
    logic [1:0]       read_status_input;
    logic             load_signed_input;
    logic [1:0]       address_low_input;
    logic [31:0]      mem_read_data;
    logic             mem_read_valid;
    logic             stall_output;
    logic [4:0]       destination_register_number;
    logic [31:0]      write_back_data;
    logic [4:0]       write_back_destination_register_number;
    logic [31:0]      write_back_result_forward;
    logic             write_back_forward_enable;
    logic [CNT_W-1:0] retired_count;

    write_back_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk                                    (clk),
        .reset                                  (reset),
        .write_back_type_input                  (write_back_type_input),
        .destination_register_number_input      (destination_register_number_input),
        .alu_result_input                       (alu_result_input),
        .pc_input                               (pc_input),
        .read_status_input                      (read_status_input),
        .load_signed_input                      (load_signed_input),
        .address_low_input                      (address_low_input),
        .mem_read_data                          (mem_read_data),
        .mem_read_valid                         (mem_read_valid),
        .stall_output                           (stall_output),
        .destination_register_number            (destination_register_number),
        .write_back_data                        (write_back_data),
        .write_back_destination_register_number (write_back_destination_register_number),
        .write_back_result_forward              (write_back_result_forward),
        .write_back_forward_enable              (write_back_forward_enable),
        .retired_count                          (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t            expQ[$];
    int              testsRun    = 0;
    int              testsFailed = 0;
    bit              monitorOn   = 1'b0;
    bit              spuriousEn  = 1'b0;
    longint unsigned expRetired  = 0;
    bit              memPending  = 1'b0;
    int              memDelay    = 0;
    logic [31:0]     memWord     = '0;
    int              stallCycles = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] status, input bit sgn);
        longint unsigned raw;
        longint unsigned full;
        int              bits;
        if (status == READ_BYTE) begin
            raw  = (longint'(word) >> (8 * int'(off))) % 256;
            bits = 8;
        end else if (status == READ_HALF) begin
            raw  = (longint'(word) >> (16 * (int'(off) / 2))) % 65536;
            bits = 16;
        end else begin
            return word;
        end
        full = raw;
        if (sgn && raw >= (64'd1 << (bits - 1))) begin
            full = raw + 64'h1_0000_0000 - (64'd1 << bits);
        end
        return full[31:0];
    endfunction

    // Memory responder: one call per clock, just after the rising edge.
    task automatic memTick(input bit accepted, input bit newIsMem, input int newDelay, input logic [31:0] newWord);
        bit respond;
        if (memPending && mem_read_valid) begin
            memPending = 1'b0;
        end else if (memPending && memDelay > 0) begin
            memDelay--;
        end
        if (accepted && newIsMem) begin
            memPending = 1'b1;
            memDelay   = newDelay;
            memWord    = newWord;
        end
        respond        = memPending && (memDelay == 0);
        mem_read_valid = respond || (spuriousEn && !memPending && ($urandom_range(0, 3) == 0));
        mem_read_data  = respond ? memWord : $urandom;
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] pc, input logic [1:0] rs, input bit sgn,
                                 input logic [1:0] off, input int delay, input logic [31:0] word);
        bit          wasStall;
        int          guard;
        logic [31:0] d;
        write_back_type_input             = t;
        destination_register_number_input = rd;
        alu_result_input                  = alu;
        pc_input                          = pc;
        read_status_input                 = rs;
        load_signed_input                 = sgn;
        address_low_input                 = off;
        if (t != WB_HICCUP) begin
            expRetired++;
            if (rd != 5'd0) begin
                if (t == WB_ALU)      d = alu;
                else if (t == WB_PC4) d = pc + 32'd4;
                else                  d = refLoad(word, off, rs, sgn);
                expQ.push_back('{rd: rd, data: d});
            end
        end
        guard = 0;
        do begin
            @(negedge clk);
            wasStall = stall_output;
            @(posedge clk);
            #1;
            if (wasStall) stallCycles++;
            memTick(!wasStall, t == WB_MEM, delay, word);
            guard++;
            if (guard > 200) begin
                checkOutput("accept_timeout", 64'd1, 64'd0);
                wasStall = 1'b0;
            end
        end while (wasStall);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(WB_HICCUP, 5'd0, '0, '0, READ_NONE, 1'b0, 2'd0, 0, '0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (monitorOn) begin
            if (write_back_forward_enable) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_commit", {59'd0, destination_register_number}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("commit_rd", {59'd0, destination_register_number}, {59'd0, e.rd});
                    checkOutput("fwd_rd", {59'd0, write_back_destination_register_number}, {59'd0, e.rd});
                    checkOutput("commit_data", {32'd0, write_back_data}, {32'd0, e.data});
                    checkOutput("fwd_data", {32'd0, write_back_result_forward}, {32'd0, e.data});
                end
            end else begin
                checkOutput("bubble_rd", {59'd0, destination_register_number}, 64'd0);
                checkOutput("bubble_fwd_rd", {59'd0, write_back_destination_register_number}, 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CNT_W-1:0] retiredBefore;
        logic [1:0]       t;
        logic [4:0]       rd;
        logic [1:0]       off;
        logic [31:0]      alu;

        reset                             = 1'b1;
        write_back_type_input             = WB_HICCUP;
        destination_register_number_input = '0;
        alu_result_input                  = '0;
        pc_input                          = '0;
        read_status_input                 = READ_NONE;
        load_signed_input                 = 1'b0;
        address_low_input                 = '0;
        mem_read_data                     = '0;
        mem_read_valid                    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_stall", {63'd0, stall_output}, 64'd0);
        checkOutput("reset_rd", {59'd0, destination_register_number}, 64'd0);
        checkOutput("reset_data", {32'd0, write_back_data}, 64'd0);
        checkOutput("reset_fwd_en", {63'd0, write_back_forward_enable}, 64'd0);
        checkOutput("reset_retired", retired_count, 64'd0);
        @(posedge clk);
        #1;
        monitorOn = 1'b1;

        // ALU result appears two edges after it is presented, then a bubble follows.
        applyStimulus(WB_ALU, 5'd5, 32'h0000_1234, 32'h100, READ_NONE, 1'b0, 2'd0, 0, '0);
        applyStimulus(WB_HICCUP, 5'd0, '0, '0, READ_NONE, 1'b0, 2'd0, 0, '0);
        checkOutput("alu_latency_rd", {59'd0, destination_register_number}, 64'd5);
        checkOutput("alu_latency_data", {32'd0, write_back_data}, 64'h1234);
        idle(2);

        // Signed byte load with data already valid: no stall.
        stallCycles = 0;
        applyStimulus(WB_MEM, 5'd9, 32'h2002, 32'h104, READ_BYTE, 1'b1, 2'd2, 0, 32'h0080_0000);
        applyStimulus(WB_HICCUP, 5'd0, '0, '0, READ_NONE, 1'b0, 2'd0, 0, '0);
        checkOutput("lb_data", {32'd0, write_back_data}, 64'hFFFF_FF80);
        checkOutput("lb_no_stall", stallCycles, 64'd0);
        idle(2);

        // Unsigned half load with three cycles of memory latency.
        applyStimulus(WB_MEM, 5'd10, 32'h3003, 32'h108, READ_HALF, 1'b0, 2'd3, 3, 32'hBEEF_1234);
        stallCycles = 0;
        applyStimulus(WB_HICCUP, 5'd0, '0, '0, READ_NONE, 1'b0, 2'd0, 0, '0);
        checkOutput("lhu_stall_cycles", stallCycles, 64'd3);
        checkOutput("lhu_data", {32'd0, write_back_data}, 64'h0000_BEEF);
        idle(2);

        // PC+4 wraparound, then an rd=0 ALU op that retires without a write.
        applyStimulus(WB_PC4, 5'd1, 32'h5555_5555, 32'hFFFF_FFFC, READ_NONE, 1'b0, 2'd0, 0, '0);
        applyStimulus(WB_ALU, 5'd0, 32'hDEAD_BEEF, 32'h10C, READ_NONE, 1'b0, 2'd0, 0, '0);
        applyStimulus(WB_HICCUP, 5'd0, '0, '0, READ_NONE, 1'b0, 2'd0, 0, '0);
        checkOutput("rd0_no_write", {59'd0, destination_register_number}, 64'd0);
        checkOutput("rd0_no_fwd", {63'd0, write_back_forward_enable}, 64'd0);
        idle(2);

        // Ten back-to-back ALU ops.
        retiredBefore = retired_count;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(WB_ALU, 5'(i + 11), $urandom, 32'(i * 4), READ_NONE, 1'b0, 2'd0, 0, '0);
        end
        idle(3);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("retired_ten", retired_count - retiredBefore, 64'd10);
`else
        checkOutput("retired_tied_zero", retired_count, 64'd0);
`endif

        // Randomized mix with spurious valid pulses while no load is pending.
        spuriousEn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            t   = 2'($urandom_range(0, 3));
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            off = 2'($urandom_range(0, 3));
            alu = $urandom;
            alu[1:0] = off;
            applyStimulus(t, rd, alu, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          off, $urandom_range(0, 3), $urandom);
        end
        spuriousEn = 1'b0;
        idle(4);
        checkOutput("queue_drained", expQ.size(), 64'd0);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("retired_total", retired_count, expRetired);
`else
        checkOutput("retired_total_zero", retired_count, 64'd0);
`endif

        // Reset while a load waits, then a late valid pulse must be ignored.
        applyStimulus(WB_MEM, 5'd7, 32'h4000, 32'h200, READ_WORD, 1'b0, 2'd0, 50, 32'hCAFE_F00D);
        write_back_type_input = WB_HICCUP;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            memTick(1'b0, 1'b0, 0, '0);
        end
        @(negedge clk);
        checkOutput("wait_mem_stall", {63'd0, stall_output}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        expQ.delete();
        expRetired     = 0;
        memPending     = 1'b0;
        mem_read_valid = 1'b1;
        mem_read_data  = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("post_reset_stall", {63'd0, stall_output}, 64'd0);
        @(posedge clk);
        #1;
        mem_read_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_rd", {59'd0, destination_register_number}, 64'd0);
            checkOutput("post_reset_data", {32'd0, write_back_data}, 64'd0);
            checkOutput("post_reset_fwd_en", {63'd0, write_back_forward_enable}, 64'd0);
            checkOutput("post_reset_stall_hold", {63'd0, stall_output}, 64'd0);
        end
        checkOutput("post_reset_retired", retired_count, 64'd0);
        monitorOn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
